// File: rtl/idct_2d.sv
// -----------------------------------------------------------------------------
// idct_2d
//   Inverse 2-D DCT for one 8x8 block. Coefficients are captured on a start
//   request, then one reconstructed pixel is computed and registered per clock
//   in row-major (x, then y) order. The finished block is held on the outputs.
//
// Ports
//   clk             : single clock, rising edge
//   rst_n           : asynchronous active-low reset
//   start_block     : transform request, sampled only while idle
//   coeff_block     : signed Q16.0 coefficients [u][v] (u = row frequency)
//   pixel_block_out : signed Q9.0 reconstructed pixels [x][y], registered
//   busy            : high whenever the FSM is not idle
//   block_done      : one-cycle pulse once all 64 pixels are valid
//   state           : FSM state, exposed for observation (0 idle, 1 calc, 2 done)
//
// Handshake: start_block is a level request with no ready/ack. It is accepted
// on any rising edge where the FSM is idle; while busy it is ignored and never
// queued, so holding it high yields back-to-back blocks every 66 cycles.
// -----------------------------------------------------------------------------
module idct_2d #(
    parameter int BLOCK_SIZE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_block,
    input  logic signed [15:0] coeff_block     [BLOCK_SIZE][BLOCK_SIZE],
    output logic signed [8:0]  pixel_block_out [BLOCK_SIZE][BLOCK_SIZE],
    output logic              busy,
    output logic              block_done,
    output logic [1:0]        state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] LAST = 3'(BLOCK_SIZE - 1);
    localparam logic signed [57:0] HALF = 58'sd2147483648;

    logic [2:0]         x_cnt;
    logic [2:0]         y_cnt;
    logic signed [15:0] coeff_q [BLOCK_SIZE][BLOCK_SIZE];

    // b(pos, freq) = alpha(freq) * C[pos][freq], Q2.16.
    // C[pos][freq] = round(256*cos((2*pos+1)*freq*pi/16)), the same values as
    // the shared cosine table. The angle is folded into the first quadrant so
    // only the nine magnitudes for multiples of pi/16 are needed.
    function automatic logic signed [17:0] basis(input logic [2:0] pos,
                                                 input logic [2:0] freq);
        int m;
        int mag;
        int alpha;
        logic neg;
        m   = ((2 * int'(pos) + 1) * int'(freq)) % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        case (m)
            0:       mag = 256;
            1:       mag = 251;
            2:       mag = 237;
            3:       mag = 213;
            4:       mag = 181;
            5:       mag = 142;
            6:       mag = 98;
            7:       mag = 50;
            default: mag = 0;
        endcase
        alpha = (freq == 3'd0) ? 91 : 128;   // 9'h05B and 9'h080
        return 18'(neg ? -(alpha * mag) : (alpha * mag));
    endfunction

    logic signed [17:0] bx [BLOCK_SIZE];
    logic signed [17:0] by [BLOCK_SIZE];

    always_comb begin
        for (int u = 0; u < BLOCK_SIZE; u++) begin
            bx[u] = basis(x_cnt, 3'(u));
            by[u] = basis(y_cnt, 3'(u));
        end
    end

    // Full-precision 64-term sum; no truncation before the final rounding.
    logic signed [57:0] acc;
    logic signed [35:0] prod_b;
    logic signed [51:0] term;

    always_comb begin
        acc    = '0;
        prod_b = '0;
        term   = '0;
        for (int u = 0; u < BLOCK_SIZE; u++) begin
            for (int v = 0; v < BLOCK_SIZE; v++) begin
                prod_b = 36'(bx[u]) * 36'(by[v]);
                term   = 52'(prod_b) * 52'(coeff_q[u][v]);
                acc    = acc + 58'(term);
            end
        end
    end

    // Round half up at bit 32, then clamp to the 9-bit signed range.
    logic signed [57:0] rounded;
    logic signed [8:0]  pixel_val;

    always_comb begin
        rounded = (acc + HALF) >>> 32;
        if (rounded > 58'sd255)
            pixel_val = 9'sd255;
        else if (rounded < -58'sd256)
            pixel_val = -9'sd256;
        else
            pixel_val = rounded[8:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x_cnt <= '0;
            y_cnt <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                for (int j = 0; j < BLOCK_SIZE; j++) begin
                    coeff_q[i][j]         <= '0;
                    pixel_block_out[i][j] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_block) begin
                        coeff_q <= coeff_block;
                        x_cnt   <= '0;
                        y_cnt   <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    pixel_block_out[x_cnt][y_cnt] <= pixel_val;
                    y_cnt <= y_cnt + 3'd1;
                    if (y_cnt == LAST) begin
                        x_cnt <= x_cnt + 3'd1;
                        if (x_cnt == LAST) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign block_done = (state == DONE);

endmodule

// File: tb/tb_idct_2d.sv
// -----------------------------------------------------------------------------
// tb_idct_2d
//   Self-checking bench for idct_2d. Expected pixels come from a direct
//   evaluation of the inverse-transform formula with integer arithmetic, and
//   the round-trip test uses a floating-point forward DCT.
// -----------------------------------------------------------------------------
module tb_idct_2d;

    logic              clk;
    logic              rst_n;
    logic              start_block;
    logic signed [15:0] coeff_block     [8][8];
    logic signed [8:0]  pixel_block_out [8][8];
    logic              busy;
    logic              block_done;
    logic [1:0]        state;

    int errors = 0;
    int checks = 0;

    int blk  [8][8];
    int orig [8][8];
    int ctab [8][8];
    logic [8:0] exp_q[$];

    idct_2d #(.BLOCK_SIZE(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_block     (start_block),
        .coeff_block     (coeff_block),
        .pixel_block_out (pixel_block_out),
        .busy            (busy),
        .block_done      (block_done),
        .state           (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int rnd(input real r);
        return $rtoi($floor(r + 0.5));
    endfunction

    task automatic init_tables();
        for (int x = 0; x < 8; x++)
            for (int u = 0; u < 8; u++)
                ctab[x][u] = rnd(256.0 * $cos((2.0 * x + 1.0) * u * 3.14159265358979 / 16.0));
    endtask

    function automatic int alpha_q(input int k);
        return (k == 0) ? 91 : 128;
    endfunction

    // Push the 64 expected pixels of blk, in x-major order.
    task automatic push_model();
        longint acc;
        longint r;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                acc = 0;
                for (int u = 0; u < 8; u++)
                    for (int v = 0; v < 8; v++)
                        acc += longint'(alpha_q(u) * ctab[x][u]) *
                               longint'(alpha_q(v) * ctab[y][v]) * longint'(blk[u][v]);
                r = (acc + 64'sd2147483648) >>> 32;
                if (r > 255) r = 255;
                if (r < -256) r = -256;
                exp_q.push_back(9'(r));
            end
        end
    endtask

    task automatic forward_dct();
        real s;
        real au;
        real av;
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                s = 0.0;
                for (int x = 0; x < 8; x++)
                    for (int y = 0; y < 8; y++)
                        s += orig[x][y] *
                             $cos((2.0 * x + 1.0) * u * 3.14159265358979 / 16.0) *
                             $cos((2.0 * y + 1.0) * v * 3.14159265358979 / 16.0);
                au = (u == 0) ? $sqrt(0.125) : 0.5;
                av = (v == 0) ? $sqrt(0.125) : 0.5;
                blk[u][v] = rnd(au * av * s);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_blk();
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++)
                blk[u][v] = 0;
    endtask

    task automatic apply_coeffs();
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++)
                coeff_block[u][v] = 16'(blk[u][v]);
    endtask

    // Start one block and follow it to idle. done_k is the first edge offset
    // after T where block_done is seen, busy_n the number of busy samples.
    task automatic run_block(output int done_k, output int busy_n, output int done_n);
        @(negedge clk);
        start_block = 1'b1;
        @(posedge clk);
        #1;
        start_block = 1'b0;
        done_k = -1;
        done_n = 0;
        busy_n = busy ? 1 : 0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (block_done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start_block = 1'b0;
        clear_blk();
        apply_coeffs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                checks++;
                if (pixel_block_out[x][y] !== 9'd0) begin
                    errors++;
                    $display("FAIL reset_pixel(%0d,%0d) got %0d exp 0", x, y, pixel_block_out[x][y]);
                end
            end
        checks++;
        if (busy !== 1'b0 || block_done !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b done=%b state=%0d exp 0/0/0", busy, block_done, state);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (block_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_done got %b exp 0", block_done);
            end
        end
    endtask

    task automatic test_zero_block();
        int dk, bn, dn;
        clear_blk();
        apply_coeffs();
        run_block(dk, bn, dn);
        checks++;
        if (dk != 64 || dn != 1) begin
            errors++;
            $display("FAIL zero_done_timing got k=%0d n=%0d exp k=64 n=1", dk, dn);
        end
        checks++;
        if (bn != 65) begin
            errors++;
            $display("FAIL zero_busy_cycles got %0d exp 65", bn);
        end
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                checks++;
                if (pixel_block_out[x][y] !== 9'd0) begin
                    errors++;
                    $display("FAIL zero_pixel(%0d,%0d) got %0d exp 0", x, y, pixel_block_out[x][y]);
                end
            end
    endtask

    // Follows the previous all-zero block, so untouched pixels read 0.
    task automatic test_dc_timing();
        clear_blk();
        blk[0][0] = 800;
        apply_coeffs();
        @(negedge clk);
        start_block = 1'b1;
        @(posedge clk);
        #1;
        start_block = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            if (k == 3 || k == 4) begin
                checks++;
                if (pixel_block_out[0][3] !== ((k == 4) ? 9'sd101 : 9'sd0)) begin
                    errors++;
                    $display("FAIL dc_px03_edge%0d got %0d exp %0d", k, pixel_block_out[0][3], (k == 4) ? 101 : 0);
                end
            end
            if (k == 8 || k == 9) begin
                checks++;
                if (pixel_block_out[1][0] !== ((k == 9) ? 9'sd101 : 9'sd0)) begin
                    errors++;
                    $display("FAIL dc_px10_edge%0d got %0d exp %0d", k, pixel_block_out[1][0], (k == 9) ? 101 : 0);
                end
            end
        end
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                checks++;
                if (pixel_block_out[x][y] !== 9'sd101) begin
                    errors++;
                    $display("FAIL dc800_pixel(%0d,%0d) got %0d exp 101", x, y, pixel_block_out[x][y]);
                end
            end
    endtask

    task automatic test_saturation();
        int dk, bn, dn;
        logic signed [8:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            clear_blk();
            blk[0][0] = (pass == 0) ? 4000 : -4000;
            want = (pass == 0) ? 9'sd255 : -9'sd256;
            apply_coeffs();
            run_block(dk, bn, dn);
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++) begin
                    checks++;
                    if (pixel_block_out[x][y] !== want) begin
                        errors++;
                        $display("FAIL sat%0d_pixel(%0d,%0d) got %0d exp %0d", pass, x, y, pixel_block_out[x][y], want);
                    end
                end
        end
    endtask

    task automatic test_round_trip();
        int dk, bn, dn, d;
        logic [8:0] e;
        for (int n = 0; n < 3; n++) begin
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++)
                    orig[x][y] = int'($urandom_range(0, 127)) - 64;
            forward_dct();
            apply_coeffs();
            push_model();
            run_block(dk, bn, dn);
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (pixel_block_out[x][y] !== e) begin
                        errors++;
                        $display("FAIL rt%0d_model(%0d,%0d) got %0d exp %0d", n, x, y, pixel_block_out[x][y], $signed(e));
                    end
                    d = int'(pixel_block_out[x][y]) - orig[x][y];
                    checks++;
                    if (d > 1 || d < -1) begin
                        errors++;
                        $display("FAIL rt%0d_orig(%0d,%0d) got %0d exp %0d+-1", n, x, y, pixel_block_out[x][y], orig[x][y]);
                    end
                end
        end
    endtask

    task automatic test_random_coeffs();
        int dk, bn, dn;
        logic [8:0] e;
        for (int n = 0; n < 3; n++) begin
            for (int u = 0; u < 8; u++)
                for (int v = 0; v < 8; v++)
                    blk[u][v] = (n == 2) ? int'($urandom_range(0, 65535)) - 32768
                                         : int'($urandom_range(0, 255)) - 128;
            apply_coeffs();
            push_model();
            run_block(dk, bn, dn);
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (pixel_block_out[x][y] !== e) begin
                        errors++;
                        $display("FAIL rand%0d_pixel(%0d,%0d) got %0d exp %0d", n, x, y, pixel_block_out[x][y], $signed(e));
                    end
                end
        end
    endtask

    task automatic test_back_to_back();
        int dones[$];
        int waited;
        logic [8:0] e;
        clear_blk();
        blk[0][0] = 300;
        blk[1][2] = -200;
        blk[5][7] = 150;
        apply_coeffs();
        push_model();
        @(negedge clk);
        start_block = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (block_done) dones.push_back(i);
        end
        @(negedge clk);
        start_block = 1'b0;
        waited = 0;
        while (busy && waited < 80) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL b2b_idle_timeout got busy=1 exp 0");
        end
        checks++;
        if (dones.size() != 3) begin
            errors++;
            $display("FAIL b2b_done_count got %0d exp 3", dones.size());
        end else begin
            checks++;
            if (dones[0] != 64 || dones[1] != 130 || dones[2] != 196) begin
                errors++;
                $display("FAIL b2b_done_spacing got %0d,%0d,%0d exp 64,130,196", dones[0], dones[1], dones[2]);
            end
        end
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_block_out[x][y] !== e) begin
                    errors++;
                    $display("FAIL b2b_pixel(%0d,%0d) got %0d exp %0d", x, y, pixel_block_out[x][y], $signed(e));
                end
            end
    endtask

    task automatic test_coeff_change();
        logic [8:0] e;
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++)
                blk[u][v] = int'($urandom_range(0, 511)) - 256;
        apply_coeffs();
        push_model();
        @(negedge clk);
        start_block = 1'b1;
        @(posedge clk);
        #1;
        start_block = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            if (k == 20)
                for (int u = 0; u < 8; u++)
                    for (int v = 0; v < 8; v++)
                        coeff_block[u][v] = 16'($urandom_range(0, 65535));
        end
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_block_out[x][y] !== e) begin
                    errors++;
                    $display("FAIL chg_pixel(%0d,%0d) got %0d exp %0d", x, y, pixel_block_out[x][y], $signed(e));
                end
            end
    endtask

    task automatic test_reset_mid();
        int dn;
        clear_blk();
        blk[0][0] = 800;
        apply_coeffs();
        @(negedge clk);
        start_block = 1'b1;
        @(posedge clk);
        #1;
        start_block = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pixel_block_out[0][0] !== 9'd0 || pixel_block_out[3][1] !== 9'd0 ||
            pixel_block_out[7][7] !== 9'd0) begin
            errors++;
            $display("FAIL midrst_pixels got %0d,%0d,%0d exp 0,0,0",
                     pixel_block_out[0][0], pixel_block_out[3][1], pixel_block_out[7][7]);
        end
        checks++;
        if (busy !== 1'b0 || block_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ctrl got busy=%b done=%b exp 0/0", busy, block_done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (block_done) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL midrst_done got %0d pulses exp 0", dn);
        end
        checks++;
        if (pixel_block_out[0][0] !== 9'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after got px=%0d busy=%b exp 0/0", pixel_block_out[0][0], busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        start_block = 1'b0;
        init_tables();
        test_reset();
        test_zero_block();
        test_dc_timing();
        test_saturation();
        test_round_trip();
        test_random_coeffs();
        test_back_to_back();
        test_coeff_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idct_2d.md
# idct_2d

Inverse 2-D DCT for one 8x8 block on the decoder path. It accepts a block of dequantized integer DCT coefficients and reconstructs signed, level-shifted pixel samples in the Q9.0 format that the forward transform consumes. It produces one output pixel per clock, holds the finished block on its outputs, and pulses `block_done` when all 64 pixels are valid.

## Interface
- `BLOCK_SIZE`, default 8: block dimension. Only 8 is supported, because the counters and cosine table are sized for 8.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start_block` input, 1 bit: request to transform `coeff_block`. Sampled only in IDLE.
- `coeff_block[u][v]` input, signed 16 bits x 64, Q16.0: dequantized coefficients. `u` is the row frequency and `v` is the column frequency.
- `pixel_block_out[x][y]` output, signed 9 bits x 64, Q9.0: reconstructed pixels, registered.
- `busy` output, 1 bit: high whenever state is not IDLE.
- `block_done` output, 1 bit: one-cycle pulse while in DONE.

## Operation
- **Constants**
  - `C[x][u]` is signed Q1.8 and equals round(256·cos((2x+1)uπ/16)). It is loaded from `cosine_vals.mem`, the same table the forward transform uses.
  - alpha(0) = 9'h05B (≈0.3536). alpha(k≠0) = 9'h080 (0.5). Both are Q1.8.
- **State machine:** IDLE → CALC → DONE → IDLE.
  - IDLE: when `start_block`=1, copy all 64 coefficients into an internal coefficient register, clear the counters (x=0, y=0), and go to CALC. When `start_block`=0, stay in IDLE.
  - CALC: compute pixel (x,y) combinationally from the registered coefficients and write it into `pixel_block_out[x][y]` at the end of the cycle. Advance y first; when y wraps 7→0, increment x. At (7,7), write the pixel and go to DONE.
  - DONE: `block_done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start_block` is ignored in CALC and DONE. It is not queued.
- Changing `coeff_block` after the IDLE capture has no effect on the block in flight.
- **Arithmetic per pixel**
  - b(x,u) = alpha(u)·C[x][u], signed 18 bits, Q2.16.
  - term(u,v) = b(x,u)·b(y,v)·coeff(u,v), signed 52 bits, Q20.32.
  - acc = sum of the 64 terms, signed 58 bits. No intermediate truncation is allowed.
  - Rounding: r = (acc + 2^31) >>> 32, arithmetic shift (round half up).
  - Saturation: r is clamped to [-256, 255] to form the 9-bit output.
- **Output hold:** `pixel_block_out` entries change only when written in CALC. A completed block stays stable from `block_done` until the first write of the next block, which is pixel (0,0).

## Timing
- **Reset values:** `pixel_block_out` all 0, `block_done`=0, `busy`=0. State resets to IDLE, counters to 0 and the coefficient register to 0.
- **Reset mid-operation:** `rst_n` low in any state asynchronously forces the reset values above. No `block_done` is produced for the aborted block.
- **Per-block cycle count:** `start_block` is sampled high in IDLE at edge T.
  - Pixel (x,y) is registered at edge T+1+8x+y.
  - The last pixel (7,7) is registered at edge T+64.
  - `block_done` and `busy` are high between edges T+64 and T+65 (the DONE cycle).
  - State is IDLE after edge T+65. The earliest next accepted start is at edge T+66, giving one block per 66 cycles.
- **Busy window:** `busy` rises after edge T and falls after edge T+65.
- **Overlapping start:** `start_block` held high continuously produces back-to-back blocks every 66 cycles.

## Test plan
- **Reset:** assert `rst_n`=0 for 2 cycles, then release.
  - Required: all outputs 0.
  - Required: `block_done` stays 0 with `start_block`=0.
- **DC only, all-zero block:** all coefficients 0 with one start.
  - Required: all 64 pixels 0.
  - Required: `block_done` high exactly at cycle T+64→T+65, and `busy` for 65 cycles.
- **DC only, coeff[0][0]=800, rest 0:**
  - Required: all 64 pixels = 101.
  - Required: pixel (0,3) updates at edge T+4 and pixel (1,0) at edge T+9.
- **Saturation:** coeff[0][0]=4000, then a second block with coeff[0][0]=-4000.
  - Required: all pixels 255 for the first block and -256 for the second.
- **Round trip:** run random 8x8 Q9.0 blocks through the forward DCT model, round the outputs to integers, then feed them to `idct_2d`.
  - Required: every pixel within ±1 of the original.
  - Required: the bench model matches the RTL bit-exactly.
- **Protocol corner cases:**
  - Hold `start_block` high for 200 cycles: `block_done` pulses exactly 3 times, at 66-cycle spacing.
  - Change `coeff_block` mid-CALC: no effect on the block in flight.
  - Drop `rst_n` at cycle T+30: outputs 0 immediately, and no `block_done` is produced.
